// File: rtl/safe_lock_pkg.sv
// safe_lock_pkg: shared state encoding and default-configuration widths for the safe lock
package safe_lock_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT} state_t;
  localparam int CNT_W = $clog2(4 + 1);
  localparam int TMR_W = $clog2(1024);
  localparam int CODE_W = 4 * 4;
endpackage

// File: rtl/safe_digit_shifter.sv
// safe_digit_shifter: indexed digit capture with count, full flag and clear, first digit in the top slot
module safe_digit_shifter #(
  parameter int CODE_LEN = 4,
  parameter int DIGIT_W = 4,
  localparam int CW = $clog2(CODE_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr,
  input  logic [DIGIT_W-1:0]           din,
  output logic [CODE_LEN*DIGIT_W-1:0]  data,
  output logic [CW-1:0]                cnt,
  output logic                         full
);
  assign full = cnt == CW'(CODE_LEN);
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      data <= '0;
    end else if (wr && !full) begin
      data[(CODE_LEN - 1 - int'(cnt)) * DIGIT_W +: DIGIT_W] <= din;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/safe_lock_core.sv
// safe_lock_core: keypad lock fsm with code register, failure counter, lockout timer and reprogramming
module safe_lock_core
  import safe_lock_pkg::*;
#(
  parameter int CODE_LEN = 4,
  parameter int DIGIT_W = 4,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYC = 1024,
  parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = 16'h1234,
  localparam int CW = $clog2(CODE_LEN + 1),
  localparam int TW = $clog2(LOCKOUT_CYC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_vld,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               clear,
  input  logic               prog,
  output logic               unlocked,
  output logic               lockout,
  output logic [3:0]         fail_cnt,
  output logic [CW-1:0]      digit_cnt,
  output logic               err
);
  state_t state;
  logic [CODE_LEN*DIGIT_W-1:0] code, data;
  logic [TW-1:0] tmr;
  logic c, e, p, d, full, match, sh_wr, sh_clr;
  assign c = clear;
  assign e = enter && !clear;
  assign p = prog && !clear && !enter;
  assign d = digit_vld && !clear && !enter && !prog;
  assign match = full && data == code;
  assign sh_wr = d && (state == IDLE || state == ENTRY || state == PROG);
  assign sh_clr = state == CHECK || (c && (state == ENTRY || state == PROG)) ||
                  (p && state == OPEN) || (e && state == PROG);
  safe_digit_shifter #(.CODE_LEN(CODE_LEN), .DIGIT_W(DIGIT_W)) u_shifter (
    .clk(clk), .rst(rst), .clr(sh_clr), .wr(sh_wr), .din(digit),
    .data(data), .cnt(digit_cnt), .full(full)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      code <= RESET_CODE;
      fail_cnt <= '0;
      tmr <= '0;
      unlocked <= 1'b0;
      lockout <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE:
          if (e) err <= 1'b1;
          else if (d) state <= ENTRY;
        ENTRY:
          if (c) state <= IDLE;
          else if (e) state <= CHECK;
          else if (d && full) err <= 1'b1;
        CHECK:
          if (match) begin
            state <= OPEN;
            unlocked <= 1'b1;
            fail_cnt <= '0;
          end else begin
            err <= 1'b1;
            fail_cnt <= fail_cnt + 4'd1;
            if (fail_cnt + 4'd1 == 4'(MAX_FAILS)) begin
              state <= LOCKOUT;
              lockout <= 1'b1;
              tmr <= TW'(LOCKOUT_CYC - 1);
            end else state <= IDLE;
          end
        OPEN:
          if (c) begin
            state <= IDLE;
            unlocked <= 1'b0;
          end else if (p) state <= PROG;
        PROG:
          if (c) state <= OPEN;
          else if (e) begin
            state <= OPEN;
            if (full) code <= data;
            else err <= 1'b1;
          end else if (d && full) err <= 1'b1;
        LOCKOUT:
          if (tmr == '0) begin
            state <= IDLE;
            lockout <= 1'b0;
            fail_cnt <= '0;
          end else tmr <= tmr - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_safe_lock_core.sv
// tb_safe_lock_core: directed and randomized scoreboard bench against a digit-queue model of the lock
module tb_safe_lock_core;
  import safe_lock_pkg::*;
  localparam int LCYC = 16;
  localparam logic [CODE_W-1:0] RCODE = 16'h1234;
  typedef logic [CNT_W+6:0] obs_t;
  logic clk = 1'b0, rst = 1'b0, digit_vld = 1'b0, enter = 1'b0, clear = 1'b0, prog = 1'b0;
  logic [3:0] digit = '0;
  logic unlocked, lockout, err;
  logic [3:0] fail_cnt;
  logic [CNT_W-1:0] digit_cnt;
  int passed = 0, total = 0, cyc = 0;
  obs_t exp_q[$];
  bit is_open, programming, checking, m_err;
  int fails;
  logic [TMR_W:0] lock_left;
  int entry[$], code_q[$];

  safe_lock_core #(.LOCKOUT_CYC(LCYC), .RESET_CODE(RCODE)) dut (
    .clk(clk), .rst(rst), .digit_vld(digit_vld), .digit(digit), .enter(enter),
    .clear(clear), .prog(prog), .unlocked(unlocked), .lockout(lockout),
    .fail_cnt(fail_cnt), .digit_cnt(digit_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit entry_matches();
    if (entry.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (entry[i] != code_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input bit r, input bit c, input bit e, input bit p, input bit d, input int dg);
    m_err = 1'b0;
    if (r) begin
      is_open = 0; programming = 0; checking = 0; fails = 0; lock_left = '0;
      entry.delete();
      code_q = '{1, 2, 3, 4};
    end else if (checking) begin
      checking = 0;
      if (entry_matches()) begin
        is_open = 1; fails = 0;
      end else begin
        m_err = 1; fails++;
        if (fails == 3) lock_left = (TMR_W+1)'(LCYC);
      end
      entry.delete();
    end else if (lock_left != 0) begin
      lock_left = lock_left - 1'b1;
      if (lock_left == 0) fails = 0;
    end else if (programming) begin
      if (c) begin
        programming = 0; entry.delete();
      end else if (e) begin
        if (entry.size() == 4) code_q = entry;
        else m_err = 1;
        programming = 0; entry.delete();
      end else if (!p && d) begin
        if (entry.size() == 4) m_err = 1;
        else entry.push_back(dg);
      end
    end else if (is_open) begin
      if (c) is_open = 0;
      else if (!e && p) begin
        programming = 1; entry.delete();
      end
    end else begin
      if (c) entry.delete();
      else if (e) begin
        if (entry.size() == 0) m_err = 1;
        else checking = 1;
      end else if (!p && d) begin
        if (entry.size() == 4) m_err = 1;
        else entry.push_back(dg);
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit p, input bit d, input int dg);
    @(negedge clk);
    rst = r; clear = c; enter = e; prog = p; digit_vld = d; digit = 4'(dg);
    model(r, c, e, p, d, dg);
    exp_q.push_back({is_open, lock_left != 0, 4'(fails), CNT_W'(entry.size()), m_err});
  endtask

  task automatic press(input int dg); step(0, 0, 0, 0, 1, dg); endtask
  task automatic ent(); step(0, 0, 1, 0, 0, 0); endtask
  task automatic clr(); step(0, 1, 0, 0, 0, 0); endtask
  task automatic prg(); step(0, 0, 0, 1, 0, 0); endtask
  task automatic rst_pulse(); step(1, 0, 0, 0, 0, 0); endtask
  task automatic nop(input int n); repeat (n) step(0, 0, 0, 0, 0, 0); endtask
  task automatic code4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    obs_t want, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got = {unlocked, lockout, fail_cnt, digit_cnt, err};
        total++;
        if (got === want) passed++;
        else $display("FAIL outputs cyc=%0d: got unl=%b lock=%b fails=%0d dcnt=%0d err=%b, exp unl=%b lock=%b fails=%0d dcnt=%0d err=%b",
                      cyc, got[CNT_W+6], got[CNT_W+5], got[CNT_W+4:CNT_W+1], got[CNT_W:1], got[0],
                      want[CNT_W+6], want[CNT_W+5], want[CNT_W+4:CNT_W+1], want[CNT_W:1], want[0]);
      end
    end
  end

  initial begin
    int r, dg;
    rst_pulse(); rst_pulse();
    code4(1, 2, 3, 4); ent(); nop(2); clr(); nop(1);
    repeat (3) begin
      code4(1, 2, 3, 5); ent(); nop(1);
    end
    repeat (20) press($urandom_range(0, 15));
    nop(2);
    code4(1, 2, 3, 4); ent(); nop(1); prg(); code4(9, 8, 7, 6); ent(); clr();
    code4(1, 2, 3, 4); ent(); nop(1); code4(9, 8, 7, 6); ent(); nop(1); clr();
    rst_pulse();
    press(1); press(2); ent(); nop(1); code4(1, 2, 3, 4); press(5); ent(); nop(1); clr();
    code4(1, 2, 3, 4); step(0, 1, 1, 0, 0, 0); nop(2);
    repeat (3) begin
      code4(7, 7, 7, 7); ent(); nop(1);
    end
    nop(3); rst_pulse();
    code4(1, 2, 3, 4); ent(); nop(1); prg(); press(5); press(6); rst_pulse();
    code4(1, 2, 3, 4); ent(); nop(2); clr();
    repeat (3000) begin
      r = $urandom_range(0, 99);
      dg = (entry.size() < 4 && !programming && $urandom_range(0, 3) != 0) ?
           code_q[entry.size()] : int'($urandom_range(0, 15));
      if (r < 1) rst_pulse();
      else if (r < 8) clr();
      else if (r < 20) ent();
      else if (r < 26) prg();
      else if (r < 75) press(dg);
      else nop(1);
    end
    nop(2);
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard drain: got %0d pending, exp 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
